datapath_sequencer: RTL and testbench

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

---
 rtl/datapath_sequencer.sv | 163 ++++++++++++++++
 tb/tb_datapath_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) and three-register execute (T3-T5).
// Optional MUL/DIV writeback to HI/LO is enabled by defining DATAPATH_SEQUENCER_MULDIV_EN.
module datapath_sequencer (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic [15:0] rin,
  output logic [15:0] rout,
  output logic        pcout,
  output logic        mdrout,
  output logic        zlowout,
  output logic        pc_in,
  output logic        ir_in,
  output logic        y_in,
  output logic        zhi_in,
  output logic        zlo_in,
  output logic        hi_in,
  output logic        lo_in,
  output logic        MDRin,
  output logic        mar_in,
  output logic        Read,
  output logic [4:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic [15:0] instr_count,
  output logic        illegal
);

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned OP_W     = 5;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned CNT_W    = 16;

  localparam logic [OP_W-1:0] OP_INC = 5'b11110;
  localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

`ifdef DATAPATH_SEQUENCER_MULDIV_EN
  localparam bit MULDIV_EN = 1'b1;
`else
  localparam bit MULDIV_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
  } state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] count_q;

  logic [OP_W-1:0]  op_f;
  logic [SEL_W-1:0] ra, rb, rc;
  logic             muldiv;
  logic             trap;
  logic             unused_ir;

  assign op_f      = ir[31:27];
  assign ra        = ir[26:23];
  assign rb        = ir[22:19];
  assign rc        = ir[18:15];
  assign muldiv    = (op_f == OP_MUL) || (op_f == OP_DIV);
  assign trap      = muldiv && !MULDIV_EN;
  assign unused_ir = ^ir[14:0];

  // Outputs are pure decodes of state, so the async clear zeroes them at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_ready) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5: begin
        if (trap)       state_nxt = S_IDLE;
        else if (start) state_nxt = S_T0;
        else            state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rin     = '0;
    rout    = '0;
    pcout   = 1'b0;
    mdrout  = 1'b0;
    zlowout = 1'b0;
    pc_in   = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    zhi_in  = 1'b0;
    zlo_in  = 1'b0;
    hi_in   = 1'b0;
    lo_in   = 1'b0;
    MDRin   = 1'b0;
    mar_in  = 1'b0;
    Read    = 1'b0;
    opcode  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    busy    = (state != S_IDLE);
    case (state)
      S_T0: begin
        pcout  = 1'b1;
        mar_in = 1'b1;
        zlo_in = 1'b1;
        opcode = OP_INC;
      end
      S_T1: begin
        Read    = 1'b1;
        MDRin   = mem_ready;
        zlowout = mem_ready;
        pc_in   = mem_ready;
      end
      S_T2: begin
        mdrout = 1'b1;
        ir_in  = 1'b1;
      end
      S_T3: begin
        rout = NUM_REGS'(1'b1) << rb;
        y_in = 1'b1;
      end
      S_T4: begin
        rout   = NUM_REGS'(1'b1) << rc;
        opcode = op_f;
        zlo_in = 1'b1;
        zhi_in = 1'b1;
      end
      S_T5: begin
        if (trap) begin
          illegal = 1'b1;
        end else if (muldiv) begin
          hi_in = 1'b1;
          lo_in = 1'b1;
          done  = 1'b1;
        end else begin
          zlowout = 1'b1;
          rin     = NUM_REGS'(1'b1) << ra;
          done    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Retired-instruction counter; wraps naturally at 2^16.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       count_q <= '0;
    else if (done) count_q <= count_q + CNT_W'(1);
  end

  assign instr_count = count_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: micro-op table model, directed and random stimulus.
module tb_datapath_sequencer;

`ifdef DATAPATH_SEQUENCER_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pcout, mdrout, zlowout, pc_in, ir_in, y_in, zhi_in, zlo_in;
    logic        hi_in, lo_in, mdr_in, mar_in, read;
    logic [4:0]  opcode;
    logic        busy, done, illegal;
    logic [15:0] instr_count;
  } obs_t;

  logic        clk = 1'b0;
  logic        clr, start, mem_ready;
  logic [31:0] ir;
  logic [15:0] rin, rout, instr_count;
  logic        pcout, mdrout, zlowout, pc_in, ir_in, y_in, zhi_in, zlo_in;
  logic        hi_in, lo_in, MDRin, mar_in, Read, busy, done, illegal;
  logic [4:0]  opcode;

  datapath_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .mem_ready(mem_ready), .ir(ir),
    .rin(rin), .rout(rout), .pcout(pcout), .mdrout(mdrout), .zlowout(zlowout),
    .pc_in(pc_in), .ir_in(ir_in), .y_in(y_in), .zhi_in(zhi_in), .zlo_in(zlo_in),
    .hi_in(hi_in), .lo_in(lo_in), .MDRin(MDRin), .mar_in(mar_in), .Read(Read),
    .opcode(opcode), .busy(busy), .done(done), .instr_count(instr_count),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Model: ph is the index of the current micro-step (-1 when no instruction is active).
  int ph = -1;
  int cnt = 0;

  localparam logic [31:0] IR_ADD = {5'b00011, 4'd3, 4'd1, 4'd2, 15'd0};
  localparam logic [31:0] IR_MUL = {5'b01111, 4'd5, 4'd1, 4'd2, 15'd0};

  function automatic bit is_md(input logic [4:0] op);
    return (op == 5'b01111) || (op == 5'b10000);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{rin: rin, rout: rout, pcout: pcout, mdrout: mdrout, zlowout: zlowout,
          pc_in: pc_in, ir_in: ir_in, y_in: y_in, zhi_in: zhi_in, zlo_in: zlo_in,
          hi_in: hi_in, lo_in: lo_in, mdr_in: MDRin, mar_in: mar_in, read: Read,
          opcode: opcode, busy: busy, done: done, illegal: illegal,
          instr_count: instr_count};
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t e;
    logic [4:0] op;
    e  = '0;
    op = ir[31:27];
    if (clr) return e;
    e.instr_count = 16'(cnt);
    if (ph < 0) return e;
    e.busy = 1'b1;
    case (ph)
      0: begin e.pcout = 1'b1; e.mar_in = 1'b1; e.zlo_in = 1'b1; e.opcode = 5'b11110; end
      1: begin e.read = 1'b1; e.mdr_in = mem_ready; e.zlowout = mem_ready; e.pc_in = mem_ready; end
      2: begin e.mdrout = 1'b1; e.ir_in = 1'b1; end
      3: begin e.rout = 16'(1) << ir[22:19]; e.y_in = 1'b1; end
      4: begin
        e.rout = 16'(1) << ir[18:15]; e.opcode = op; e.zlo_in = 1'b1; e.zhi_in = 1'b1;
      end
      5: begin
        if (is_md(op)) begin
          e.hi_in = MD_EN; e.lo_in = MD_EN; e.done = MD_EN; e.illegal = !MD_EN;
        end else begin
          e.zlowout = 1'b1; e.rin = 16'(1) << ir[26:23]; e.done = 1'b1;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic advance();
    if (clr) begin
      ph = -1; cnt = 0;
      return;
    end
    case (ph)
      -1: if (start) ph = 0;
      0: ph = 1;
      1: if (mem_ready) ph = 2;
      2, 3, 4: ph = ph + 1;
      5: begin
        if (is_md(ir[31:27]) && !MD_EN) ph = -1;
        else begin
          cnt = (cnt + 1) % 65536;
          ph  = start ? 0 : -1;
        end
      end
      default: ph = -1;
    endcase
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply inputs, compare against the model mid-cycle, then let the clock edge advance both.
  task automatic step_cycle(input bit s, input bit mr, input logic [31:0] irv, output obs_t o);
    obs_t e;
    start = s; mem_ready = mr; ir = irv;
    @(negedge clk);
    o = sample();
    e = model_out();
    n_chk++;
    if (o === e) n_pass++;
    else $display("FAIL model cyc=%0d ph=%0d: got %h expected %h", cyc, ph, o, e);
    n_chk++;
    if ($countones(o.rin) <= 1 && $countones(o.rout) <= 1 && !(o.rin != 0 && o.rout != 0))
      n_pass++;
    else $display("FAIL onehot cyc=%0d: got rin=%h rout=%h expected at most one select", cyc, o.rin, o.rout);
    @(posedge clk);
    advance();
    cyc++;
    #1;
  endtask

  obs_t o;
  obs_t t [12];
  logic acc;
  int   pulses;

  initial begin
    clr = 1'b1; start = 1'b0; mem_ready = 1'b0; ir = '0;
    repeat (2) step_cycle(1'b1, 1'b1, IR_ADD, o);
    chk("reset_all_zero", 32'(o), 32'(0));
    chk("reset_count", 32'(o.instr_count), 32'(0));
    clr = 1'b0;

    // Idle with start low
    acc = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_cycle(1'b0, 1'b1, IR_ADD, o);
      acc = acc | o.busy;
    end
    chk("idle_busy", 32'(acc), 32'(0));

    // ADD, zero-wait memory
    step_cycle(1'b1, 1'b1, IR_ADD, o);
    for (int k = 0; k < 7; k++) step_cycle(1'b0, 1'b1, IR_ADD, t[k]);
    chk("add_t0_pcout", 32'(t[0].pcout), 32'(1));
    chk("add_t0_inc", 32'(t[0].opcode), 32'h1E);
    chk("add_t1_pc_in", 32'(t[1].pc_in), 32'(1));
    chk("add_t3_rout", 32'(t[3].rout), 32'h0002);
    chk("add_t4_rout", 32'(t[4].rout), 32'h0004);
    chk("add_t4_opcode", 32'(t[4].opcode), 32'd3);
    chk("add_t5_rin", 32'(t[5].rin), 32'h0008);
    chk("add_done_6th", 32'({t[4].done, t[5].done}), 32'b01);
    chk("add_count", 32'(t[6].instr_count), 32'd1);
    chk("add_back_idle", 32'(t[6].busy), 32'd0);

    // Memory wait of three T1 cycles
    step_cycle(1'b1, 1'b1, IR_ADD, o);
    for (int k = 0; k < 10; k++)
      step_cycle(1'b0, !(k >= 1 && k <= 3), IR_ADD, t[k]);
    acc = 1'b1; pulses = 0;
    for (int k = 1; k <= 3; k++) acc = acc & t[k].read & !t[k].mdr_in;
    for (int k = 0; k < 10; k++) pulses += int'(t[k].pc_in);
    chk("wait_read_no_mdr", 32'(acc), 32'(1));
    chk("wait_pc_in_pulses", 32'(pulses), 32'd1);
    chk("wait_done_at_9th", 32'({t[7].done, t[8].done}), 32'b01);
    chk("wait_count", 32'(t[9].instr_count), 32'd2);

    // MUL with start held through T5
    step_cycle(1'b1, 1'b1, IR_MUL, o);
    for (int k = 0; k < 6; k++) step_cycle(1'b1, 1'b1, IR_MUL, t[k]);
    step_cycle(1'b0, 1'b1, IR_MUL, t[6]);
    chk("mul_hi_lo", 32'({t[5].hi_in, t[5].lo_in}), 32'({MD_EN, MD_EN}));
    chk("mul_no_rin", 32'({t[5].rin, t[5].zlowout}), 32'(0));
    chk("mul_illegal_done", 32'({t[5].illegal, t[5].done}), 32'({!MD_EN, MD_EN}));
    chk("mul_next_busy", 32'(t[6].busy), 32'(MD_EN));
    chk("mul_count", 32'(t[6].instr_count), MD_EN ? 32'd3 : 32'd2);
    for (int k = 0; k < 10; k++) step_cycle(1'b0, 1'b1, IR_ADD, o);

    // Wrap from 0xFFFF with back-to-back start
    force dut.count_q = 16'hFFFF;
    #1 release dut.count_q;
    cnt = 65535;
    step_cycle(1'b1, 1'b1, IR_ADD, o);
    chk("wrap_preload", 32'(o.instr_count), 32'hFFFF);
    for (int k = 0; k < 7; k++) step_cycle(1'b1, 1'b1, IR_ADD, t[k]);
    chk("wrap_done", 32'(t[5].done), 32'd1);
    chk("wrap_t0_follows", 32'({t[6].busy, t[6].pcout}), 32'b11);
    chk("wrap_count_zero", 32'(t[6].instr_count), 32'd0);
    for (int k = 0; k < 10; k++) step_cycle(1'b0, 1'b1, IR_ADD, o);

    // Asynchronous clear during T4
    step_cycle(1'b1, 1'b1, IR_ADD, o);
    for (int k = 0; k < 4; k++) step_cycle(1'b0, 1'b1, IR_ADD, t[k]);
    #2 o = sample();
    chk("pre_clr_in_t4", 32'({o.busy, o.zhi_in}), 32'b11);
    clr = 1'b1;
    #1 o = sample();
    chk("clr_async_zero", 32'(o), 32'(0));
    chk("clr_async_count", 32'(o.instr_count), 32'(0));
    step_cycle(1'b0, 1'b1, IR_ADD, o);
    clr = 1'b0;
    step_cycle(1'b1, 1'b1, IR_ADD, o);
    step_cycle(1'b0, 1'b1, IR_ADD, o);
    chk("restart_t0", 32'({o.busy, o.pcout, o.mar_in}), 32'b111);

    // Randomized traffic
    for (int k = 0; k < 2500; k++) begin
      logic [31:0] r;
      int sel;
      r   = $urandom;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) r[31:27] = 5'b01111;
      else if (sel == 1) r[31:27] = 5'b10000;
      clr = ($urandom_range(0, 199) == 0);
      step_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, r, o);
    end
    clr = 1'b0;
    for (int k = 0; k < 12; k++) step_cycle(1'b0, 1'b1, IR_ADD, o);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
